// File: rtl/pe_array_ctrl_if.sv
// pe_array_ctrl_if: job-control, buffer and array-side signals of the PE array sequencer.
// master = sequencer, slave = job control / buffers / array.
interface pe_array_ctrl_if #(parameter int N = 4, parameter int CNT_W = 8);
   logic                 I_START;
   logic [CNT_W-1:0]     I_ROWS;
   logic                 O_BUSY;
   logic                 O_W_RD_EN;
   logic [$clog2(N)-1:0] O_W_RD_ADDR;
   logic [N-1:0]         O_W_VLD;
   logic                 O_X_RD_EN;
   logic [CNT_W-1:0]     O_X_RD_ADDR;
   logic [N-1:0]         O_X_VLD;
   logic [N-1:0]         O_D_VLD;
   logic [N-1:0]         I_OUT_VLD;
   logic                 O_RES_WR_EN;
   logic [CNT_W-1:0]     O_RES_WR_ADDR;
   logic                 O_DONE;
   logic                 O_ERR;
   modport master (
      input  I_START, I_ROWS, I_OUT_VLD,
      output O_BUSY, O_W_RD_EN, O_W_RD_ADDR, O_W_VLD, O_X_RD_EN, O_X_RD_ADDR,
             O_X_VLD, O_D_VLD, O_RES_WR_EN, O_RES_WR_ADDR, O_DONE, O_ERR
   );
   modport slave (
      output I_START, I_ROWS, I_OUT_VLD,
      input  O_BUSY, O_W_RD_EN, O_W_RD_ADDR, O_W_VLD, O_X_RD_EN, O_X_RD_ADDR,
             O_X_VLD, O_D_VLD, O_RES_WR_EN, O_RES_WR_ADDR, O_DONE, O_ERR
   );
endinterface

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: per-job sequencer for an NxN systolic array (weight load, skewed X stream, result count).
// Define PE_CTRL_TIMEOUT_EN to add a DRAIN watchdog that aborts the job with O_ERR.
module pe_array_ctrl #(
   parameter int N       = 4,
   parameter int CNT_W   = 8,
   parameter int MUL_LAT = 3
) (
   input logic             I_CLK,
   input logic             I_RST_N,
   pe_array_ctrl_if.master bus
);
   localparam int AW = $clog2(N);
   localparam int SL = N + MUL_LAT;
   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        m_q, m_d, idx_q, idx_d;
   logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]            w_vld_q, w_vld_d;
   logic [SL-1:0]           sh_q, sh_d;
   logic                    done_q, done_d, err_q, err_d;
   logic                    accept, counting, last_hit, timeout;
   assign accept   = state_q == IDLE && !done_q && bus.I_START;
   assign counting = state_q == STREAM || state_q == DRAIN;
   assign last_hit = cnt_d[N-1] == m_q;
`ifdef PE_CTRL_TIMEOUT_EN
   localparam int WD_LIM = N + MUL_LAT + 16;
   localparam int WW     = $clog2(WD_LIM + 1);
   logic [WW-1:0] wd_q;
   always_ff @(posedge I_CLK)
      wd_q <= (!I_RST_N || state_q != DRAIN) ? '0 : wd_q + 1'b1;
   assign timeout = state_q == DRAIN && !last_hit && wd_q == WW'(WD_LIM - 1);
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge I_CLK)
      if (!I_RST_N) begin
         state_q <= IDLE;
         m_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         w_vld_q <= '0;
         sh_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         w_vld_q <= w_vld_d;
         sh_q    <= sh_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE:
            if (accept) begin
               m_d   = bus.I_ROWS;
               idx_d = '0;
               if (bus.I_ROWS == '0) done_d = 1'b1;
               else state_d = LOAD_W;
            end
         LOAD_W: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == CNT_W'(N - 1)) begin
               idx_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == m_q - 1'b1) state_d = DRAIN;
         end
         DRAIN:
            if (last_hit || timeout) begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = timeout;
            end
         default: state_d = IDLE;
      endcase
   end
   // Per-column result counters saturate at M so surplus strobes never produce writes.
   always_comb begin
      cnt_d = cnt_q;
      for (int c = 0; c < N; c++)
         if (counting && bus.I_OUT_VLD[c] && cnt_q[c] != m_q) cnt_d[c] = cnt_q[c] + 1'b1;
      if (accept) cnt_d = '0;
   end
   // sh_q[k] is the X read enable delayed k+1 cycles, so sh_q[0] is x_iss.
   always_comb begin
      w_vld_d = state_q == LOAD_W ? N'(1) << idx_q[AW-1:0] : '0;
      sh_d    = timeout ? '0 : {sh_q[SL-2:0], state_q == STREAM};
   end
   always_comb begin
      bus.O_BUSY        = state_q != IDLE || done_q;
      bus.O_W_RD_EN     = state_q == LOAD_W;
      bus.O_W_RD_ADDR   = state_q == LOAD_W ? idx_q[AW-1:0] : '0;
      bus.O_W_VLD       = w_vld_q;
      bus.O_X_RD_EN     = state_q == STREAM;
      bus.O_X_RD_ADDR   = state_q == STREAM ? idx_q : '0;
      bus.O_X_VLD       = sh_q[N-1:0];
      bus.O_D_VLD       = sh_q[SL-1:MUL_LAT];
      bus.O_RES_WR_EN   = counting && bus.I_OUT_VLD[0] && cnt_q[0] != m_q;
      bus.O_RES_WR_ADDR = cnt_q[0];
      bus.O_DONE        = done_q;
      bus.O_ERR         = err_q;
   end
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: directed checks of the PE array sequencer with N=4, CNT_W=8, MUL_LAT=3.
module tb_pe_array_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   int checks = 0, errors = 0;
   logic [23:0] tr_a [0:63];
   logic [11:0] tr_b [0:63];
   logic [3:0]  inj [0:63];
   logic        st [0:63];
   pe_array_ctrl_if #(.N(4), .CNT_W(8)) bus ();
   pe_array_ctrl #(.N(4), .CNT_W(8), .MUL_LAT(3)) dut (.I_CLK(clk), .I_RST_N(rst_n), .bus(bus.master));
   always #5 clk = ~clk;
   task automatic clear_stim();
      for (int t = 0; t < 64; t++) begin
         inj[t] = 4'b0;
         st[t]  = 1'b0;
      end
   endtask
   // Cycle 0 carries the start pulse; the array model feeds back O_D_VLD delayed 4 cycles.
   task automatic run_job(input logic [7:0] m, input int ncyc, input bit model);
      logic [3:0] dh [0:63];
      for (int t = 0; t < ncyc; t++) begin
         @(posedge clk); #1;
         bus.I_START   = (t == 0) || st[t];
         bus.I_ROWS    = m;
         bus.I_OUT_VLD = inj[t] | ((model && t >= 4) ? dh[t-4] : 4'b0);
         @(negedge clk);
         dh[t]   = bus.O_D_VLD;
         tr_a[t] = {bus.O_W_RD_EN, bus.O_W_RD_ADDR, bus.O_W_VLD, bus.O_X_RD_EN, bus.O_X_RD_ADDR,
                    bus.O_X_VLD, bus.O_D_VLD};
         tr_b[t] = {bus.O_RES_WR_EN, bus.O_RES_WR_ADDR, bus.O_DONE, bus.O_ERR, bus.O_BUSY};
      end
      @(posedge clk); #1;
      bus.I_START   = 1'b0;
      bus.I_OUT_VLD = 4'b0;
   endtask
   function automatic logic [35:0] all_out();
      return {bus.O_BUSY, bus.O_W_RD_EN, bus.O_W_RD_ADDR, bus.O_W_VLD, bus.O_X_RD_EN, bus.O_X_RD_ADDR,
              bus.O_X_VLD, bus.O_D_VLD, bus.O_RES_WR_EN, bus.O_RES_WR_ADDR, bus.O_DONE, bus.O_ERR};
   endfunction
   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (all_out() !== 36'h0) begin
         errors++;
         $display("FAIL reset_por outputs got %h exp 0", all_out());
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      bus.I_START = 1'b1;
      bus.I_ROWS  = 8'd2;
      @(posedge clk); #1 bus.I_START = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.I_OUT_VLD = 4'hF;
      @(negedge clk);
      checks++;
      if (bus.O_X_RD_EN !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_stream x_rd_en got %b exp 1", bus.O_X_RD_EN);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (all_out() !== 36'h0) begin
            errors++;
            $display("FAIL reset_mid_job cyc %0d got %h exp 0", i, all_out());
         end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.O_DONE, bus.O_BUSY, bus.O_RES_WR_EN} !== 3'b000) begin
            errors++;
            $display("FAIL reset_after cyc %0d done/busy/wr got %b exp 000", i,
                     {bus.O_DONE, bus.O_BUSY, bus.O_RES_WR_EN});
         end
      end
      @(posedge clk); #1 bus.I_OUT_VLD = 4'b0;
   endtask
   task automatic test_stream();
      logic [23:0] e;
      logic [3:0]  xv, dv;
      logic        wen, xen;
      clear_stim();
      run_job(8'd2, 30, 1'b1);
      for (int t = 0; t < 30; t++) begin
         wen = t >= 1 && t <= 4;
         xen = t == 5 || t == 6;
         for (int r = 0; r < 4; r++) begin
            xv[r] = t >= 6 + r && t <= 7 + r;
            dv[r] = t >= 9 + r && t <= 10 + r;
         end
         e = {wen, wen ? 2'(t - 1) : 2'd0, (t >= 2 && t <= 5) ? 4'(1 << (t - 2)) : 4'd0,
              xen, xen ? 8'(t - 5) : 8'd0, xv, dv};
         checks++;
         if (tr_a[t] !== e) begin
            errors++;
            $display("FAIL stream cyc %0d got %h exp %h", t, tr_a[t], e);
         end
      end
   endtask
   task automatic test_results();
      logic [3:0] e;
      logic       wr;
      clear_stim();
      run_job(8'd2, 30, 1'b1);
      for (int t = 0; t < 30; t++) begin
         wr = t == 13 || t == 14;
         e  = {wr, t == 18, 1'b0, t >= 1 && t <= 18};
         checks++;
         if ({tr_b[t][11], tr_b[t][2:0]} !== e) begin
            errors++;
            $display("FAIL results cyc %0d wr/done/err/busy got %b exp %b", t, {tr_b[t][11], tr_b[t][2:0]}, e);
         end
         if (wr) begin
            checks++;
            if (tr_b[t][10:3] !== 8'(t - 13)) begin
               errors++;
               $display("FAIL res_addr cyc %0d got %0d exp %0d", t, tr_b[t][10:3], t - 13);
            end
         end
      end
   endtask
   task automatic test_extra_pulses();
      int n;
      clear_stim();
      inj[15] = 4'b0001;
      run_job(8'd2, 24, 1'b1);
      n = 0;
      for (int t = 0; t < 24; t++) n += int'(tr_b[t][11]);
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL extra_writes got %0d exp 2", n);
      end
      checks++;
      if (tr_b[15][11] !== 1'b0) begin
         errors++;
         $display("FAIL extra_pulse_wr cyc 15 got %b exp 0", tr_b[15][11]);
      end
   endtask
   task automatic test_zero_rows();
      logic [4:0] e;
      clear_stim();
      run_job(8'd0, 6, 1'b0);
      for (int t = 0; t < 6; t++) begin
         e = {1'b0, 1'b0, t == 1, 1'b0, t == 1};
         checks++;
         if ({tr_a[t][23], tr_a[t][16], tr_b[t][2:0]} !== e) begin
            errors++;
            $display("FAIL zero_rows cyc %0d wen/xen/done/err/busy got %b exp %b", t,
                     {tr_a[t][23], tr_a[t][16], tr_b[t][2:0]}, e);
         end
      end
   endtask
   task automatic test_start_ignored();
      logic [2:0] e;
      clear_stim();
      st[5]  = 1'b1;
      st[18] = 1'b1;
      run_job(8'd2, 26, 1'b1);
      for (int t = 0; t < 26; t++) begin
         e = {t >= 1 && t <= 4, t == 18, t >= 1 && t <= 18};
         checks++;
         if ({tr_a[t][23], tr_b[t][2], tr_b[t][0]} !== e) begin
            errors++;
            $display("FAIL start_ignored cyc %0d wen/done/busy got %b exp %b", t,
                     {tr_a[t][23], tr_b[t][2], tr_b[t][0]}, e);
         end
      end
   endtask
   task automatic test_timeout();
      logic [2:0] e;
      clear_stim();
      run_job(8'd2, 40, 1'b0);
      for (int t = 7; t < 40; t++) begin
`ifdef PE_CTRL_TIMEOUT_EN
         e = {t == 30, t == 30, t <= 30};
`else
         e = 3'b001;
`endif
         checks++;
         if (tr_b[t][2:0] !== e) begin
            errors++;
            $display("FAIL timeout cyc %0d done/err/busy got %b exp %b", t, tr_b[t][2:0], e);
         end
      end
   endtask
   initial begin
      bus.I_START   = 1'b0;
      bus.I_ROWS    = 8'd0;
      bus.I_OUT_VLD = 4'b0;
      test_reset();
      test_stream();
      test_results();
      test_extra_pulses();
      test_zero_rows();
      test_start_ignored();
      test_timeout();
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
